// File: rtl/alu_seq_control.sv
// Sequential ALU control block: decodes ALUOP/OPCode, computes single-step
// operations in one cycle and logical shifts one bit per cycle, then holds
// the result under a valid/ready handshake until the consumer takes it.
module alu_seq_control #(
  parameter int WIDTH = 64,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             InValid,
  output logic             InReady,
  input  logic [1:0]       ALUOP,
  input  logic [10:0]      OPCode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [SHW-1:0]   Shamt,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic [3:0]       Operation,
  output logic             Illegal
);

  // FSM encoding
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_EXEC = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  // Operation codes
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_ORR  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_LSL  = 4'b0011;
  localparam logic [3:0] OP_LSR  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_PASS = 4'b0111;
  localparam logic [3:0] OP_ILL  = 4'b1111;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_op;
  logic             r_illegal;
  logic             r_shl;
  logic [SHW-1:0]   r_cnt;

  logic [3:0]       w_op;
  logic             w_illegal;
  logic             w_is_shift;
  logic [WIDTH-1:0] w_result;

  // Decode the live request fields into an operation code
  always_comb begin
    w_op      = OP_ILL;
    w_illegal = 1'b1;
    case (ALUOP)
      2'b00: begin
        w_op      = OP_ADD;
        w_illegal = 1'b0;
      end
      2'b01: begin
        w_op      = OP_PASS;
        w_illegal = 1'b0;
      end
      2'b10: begin
        w_illegal = 1'b0;
        if (OPCode == 11'b10001011000)        w_op = OP_ADD;
        else if (OPCode == 11'b11001011000)   w_op = OP_SUB;
        else if (OPCode == 11'b10001010000)   w_op = OP_AND;
        else if (OPCode == 11'b10101010000)   w_op = OP_ORR;
        else if (OPCode[10:1] == 10'b1011001000) w_op = OP_ORR;  // ORRI, low bit is immediate
        else if (OPCode == 11'b11010011011)   w_op = OP_LSL;
        else if (OPCode == 11'b11010011010)   w_op = OP_LSR;
        else begin
          w_op      = OP_ILL;
          w_illegal = 1'b1;
        end
      end
      default: begin
        w_op      = OP_ILL;
        w_illegal = 1'b1;
      end
    endcase
  end

  // Single-step result; for shifts this is the starting value (A), which is
  // also the final value when Shamt is zero
  always_comb begin
    w_is_shift = (w_op == OP_LSL) || (w_op == OP_LSR);
    w_result   = '0;
    case (w_op)
      OP_ADD:         w_result = A + B;
      OP_SUB:         w_result = A - B;
      OP_AND:         w_result = A & B;
      OP_ORR:         w_result = A | B;
      OP_PASS:        w_result = B;
      OP_LSL, OP_LSR: w_result = A;
      default:        w_result = '0;
    endcase
  end

  // Control FSM and datapath registers; request inputs are only looked at in IDLE
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_state   <= ST_IDLE;
      r_result  <= '0;
      r_op      <= 4'b0000;
      r_illegal <= 1'b0;
      r_shl     <= 1'b0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (InValid) begin
            r_op      <= w_op;
            r_illegal <= w_illegal;
            r_result  <= w_result;
            r_shl     <= (w_op == OP_LSL);
            if (w_is_shift && (Shamt != '0)) begin
              r_cnt   <= Shamt;
              r_state <= ST_EXEC;
            end else begin
              r_cnt   <= '0;
              r_state <= ST_DONE;
            end
          end
        end
        ST_EXEC: begin
          r_result <= r_shl ? (r_result << 1) : (r_result >> 1);
          r_cnt    <= r_cnt - SHW'(1);
          if (r_cnt == SHW'(1)) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (OutReady) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign InReady   = (r_state == ST_IDLE);
  assign OutValid  = (r_state == ST_DONE);
  assign Result    = r_result;
  assign Zero      = (r_result == '0);
  assign Operation = r_op;
  assign Illegal   = r_illegal;

endmodule

// File: tb/tb_alu_seq_control.sv
// Directed bench for alu_seq_control: a 64-bit instance for the main cases
// and an 8-bit instance for the narrow-width wrap case.
module tb_alu_seq_control;

  logic        CLOCK;
  logic        RESET;

  // 64-bit instance signals
  logic        InValid, InReady, OutValid, OutReady, Zero, Illegal;
  logic [1:0]  ALUOP;
  logic [10:0] OPCode;
  logic [63:0] A, B, Result;
  logic [5:0]  Shamt;
  logic [3:0]  Operation;

  // 8-bit instance signals
  logic        InValid_8, InReady_8, OutValid_8, OutReady_8, Zero_8, Illegal_8;
  logic [1:0]  ALUOP_8;
  logic [10:0] OPCode_8;
  logic [7:0]  A_8, B_8, Result_8;
  logic [2:0]  Shamt_8;
  logic [3:0]  Operation_8;

  int n_tests = 0;
  int n_fail  = 0;

  alu_seq_control #(.WIDTH(64)) u_dut (
    .CLOCK(CLOCK), .RESET(RESET), .InValid(InValid), .InReady(InReady),
    .ALUOP(ALUOP), .OPCode(OPCode), .A(A), .B(B), .Shamt(Shamt),
    .OutValid(OutValid), .OutReady(OutReady), .Result(Result), .Zero(Zero),
    .Operation(Operation), .Illegal(Illegal)
  );

  alu_seq_control #(.WIDTH(8)) u_dut8 (
    .CLOCK(CLOCK), .RESET(RESET), .InValid(InValid_8), .InReady(InReady_8),
    .ALUOP(ALUOP_8), .OPCode(OPCode_8), .A(A_8), .B(B_8), .Shamt(Shamt_8),
    .OutValid(OutValid_8), .OutReady(OutReady_8), .Result(Result_8), .Zero(Zero_8),
    .Operation(Operation_8), .Illegal(Illegal_8)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present a request and return #1 after the edge that accepts it
  task automatic send(input logic [1:0] op, input logic [10:0] opc,
                      input logic [63:0] a, input logic [63:0] b, input logic [5:0] sh);
    int guard;
    guard = 0;
    @(negedge CLOCK);
    while (!InReady && guard < 100) begin
      @(negedge CLOCK);
      guard++;
    end
    check("ready_before_send", {63'd0, InReady}, 64'd1);
    InValid = 1'b1;
    ALUOP   = op;
    OPCode  = opc;
    A       = a;
    B       = b;
    Shamt   = sh;
    @(posedge CLOCK);
    #1;
    InValid = 1'b0;
  endtask

  // Count edges from acceptance until OutValid is seen; note whether InReady stayed low
  task automatic wait_done(output int lat, output logic ready_low);
    lat       = 1;
    ready_low = 1'b1;
    while (!OutValid && lat < 200) begin
      if (InReady) ready_low = 1'b0;
      @(posedge CLOCK);
      #1;
      lat++;
    end
    if (InReady) ready_low = 1'b0;
  endtask

  // Hand the result to the consumer and confirm the handshake edge
  task automatic take_result(input string tag);
    @(negedge CLOCK);
    OutReady = 1'b1;
    @(posedge CLOCK);
    #1;
    OutReady = 1'b0;
    check({tag, "_outvalid_low"}, {63'd0, OutValid}, 64'd0);
    check({tag, "_inready_high"}, {63'd0, InReady}, 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [10:0] opc,
                        input logic [63:0] a, input logic [63:0] b, input logic [5:0] sh,
                        input int exp_lat, input logic [63:0] exp_res,
                        input logic [3:0] exp_op, input logic exp_ill);
    int   lat;
    logic rl;
    send(op, opc, a, b, sh);
    wait_done(lat, rl);
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_result"}, Result, exp_res);
    check({tag, "_operation"}, {60'd0, Operation}, {60'd0, exp_op});
    check({tag, "_illegal"}, {63'd0, Illegal}, {63'd0, exp_ill});
    check({tag, "_zero"}, {63'd0, Zero}, {63'd0, (exp_res == 64'd0)});
    check({tag, "_inready_low"}, {63'd0, rl}, 64'd1);
    $display("[TB] %s: latency %0d result 0x%0h op %b illegal %b", tag, lat, Result, Operation, Illegal);
    take_result(tag);
  endtask

  initial begin
    int   lat;
    logic rl;
    logic seen;

    RESET = 1'b1;
    InValid = 1'b0; OutReady = 1'b0; ALUOP = 2'b00; OPCode = '0; A = '0; B = '0; Shamt = '0;
    InValid_8 = 1'b0; OutReady_8 = 1'b0; ALUOP_8 = 2'b00; OPCode_8 = '0; A_8 = '0; B_8 = '0; Shamt_8 = '0;

    // Reset values, before any clock edge
    #2;
    check("rst_inready", {63'd0, InReady}, 64'd1);
    check("rst_outvalid", {63'd0, OutValid}, 64'd0);
    check("rst_result", Result, 64'd0);
    check("rst_zero", {63'd0, Zero}, 64'd1);
    check("rst_operation", {60'd0, Operation}, 64'd0);
    check("rst_illegal", {63'd0, Illegal}, 64'd0);
    $display("[TB] reset state checked");
    repeat (2) @(negedge CLOCK);
    RESET = 1'b0;

    // Main function, directed vectors
    run_op("sub",      2'b10, 11'b11001011000, 64'd5, 64'd7, 6'd0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0110, 1'b0);
    run_op("lsl63",    2'b10, 11'b11010011011, 64'd1, 64'd9, 6'd63, 64, 64'h8000_0000_0000_0000, 4'b0011, 1'b0);
    run_op("illegal_r",2'b10, 11'b11111111111, 64'd3, 64'd4, 6'd0, 1, 64'd0, 4'b1111, 1'b1);
    run_op("illegal_11",2'b11, 11'b10001011000, 64'd3, 64'd4, 6'd0, 1, 64'd0, 4'b1111, 1'b1);
    run_op("orri",     2'b10, 11'b10110010001, 64'hF0, 64'h0F, 6'd0, 1, 64'hFF, 4'b0001, 1'b0);
    run_op("add_d",    2'b00, 11'b00000000000, 64'd100, 64'd23, 6'd0, 1, 64'd123, 4'b0010, 1'b0);
    run_op("add_wrap", 2'b10, 11'b10001011000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 6'd0, 1, 64'd1, 4'b0010, 1'b0);
    run_op("and",      2'b10, 11'b10001010000, 64'hFF00, 64'h0FF0, 6'd0, 1, 64'h0F00, 4'b0000, 1'b0);
    run_op("orr",      2'b10, 11'b10101010000, 64'hF000, 64'h000F, 6'd0, 1, 64'hF00F, 4'b0001, 1'b0);
    run_op("passb",    2'b01, 11'b00000000000, 64'd9, 64'h55, 6'd0, 1, 64'h55, 4'b0111, 1'b0);
    run_op("lsr4",     2'b10, 11'b11010011010, 64'hF0, 64'hFFFF, 6'd4, 5, 64'h0F, 4'b0100, 1'b0);
    run_op("lsl0",     2'b10, 11'b11010011011, 64'h1234, 64'd0, 6'd0, 1, 64'h1234, 4'b0011, 1'b0);

    // CBZ-style pass of zero with the consumer stalled for 5 cycles
    send(2'b01, 11'b0, 64'd77, 64'd0, 6'd0);
    wait_done(lat, rl);
    check("cbz_latency", 64'(lat), 64'd1);
    for (int i = 0; i < 5; i++) begin
      check("cbz_hold_valid", {63'd0, OutValid}, 64'd1);
      check("cbz_hold_result", Result, 64'd0);
      check("cbz_hold_zero", {63'd0, Zero}, 64'd1);
      check("cbz_hold_operation", {60'd0, Operation}, 64'd7);
      @(posedge CLOCK);
      #1;
    end
    $display("[TB] cbz: held result 0x%0h zero %b for 5 cycles", Result, Zero);
    take_result("cbz");

    // Request inputs toggled while the shift is executing must be ignored
    send(2'b10, 11'b11010011011, 64'd3, 64'd0, 6'd3);
    InValid = 1'b1; ALUOP = 2'b01; A = 64'hFFFF; B = 64'hAAAA; Shamt = 6'd7;
    wait_done(lat, rl);
    InValid = 1'b0;
    check("exec_ign_latency", 64'(lat), 64'd4);
    check("exec_ign_result", Result, 64'h18);
    check("exec_ign_operation", {60'd0, Operation}, 64'd3);
    $display("[TB] exec_ignore: latency %0d result 0x%0h", lat, Result);
    take_result("exec_ign");

    // Reset during EXEC cycle 4 of a 10-bit LSR
    send(2'b10, 11'b11010011010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 6'd10);
    repeat (3) @(posedge CLOCK);
    #3;
    RESET = 1'b1;
    #1;
    check("midrst_inready", {63'd0, InReady}, 64'd1);
    check("midrst_outvalid", {63'd0, OutValid}, 64'd0);
    check("midrst_result", Result, 64'd0);
    check("midrst_zero", {63'd0, Zero}, 64'd1);
    check("midrst_operation", {60'd0, Operation}, 64'd0);
    check("midrst_illegal", {63'd0, Illegal}, 64'd0);
    @(negedge CLOCK);
    RESET = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLOCK);
      #1;
      if (OutValid) seen = 1'b1;
    end
    check("midrst_no_outvalid", {63'd0, seen}, 64'd0);
    $display("[TB] mid-exec reset: outputs cleared, no late result");

    // 8-bit instance: ADD wraps to zero
    @(negedge CLOCK);
    InValid_8 = 1'b1; ALUOP_8 = 2'b00; A_8 = 8'hFF; B_8 = 8'h01;
    @(posedge CLOCK);
    #1;
    InValid_8 = 1'b0;
    check("w8_outvalid", {63'd0, OutValid_8}, 64'd1);
    check("w8_result", {56'd0, Result_8}, 64'd0);
    check("w8_zero", {63'd0, Zero_8}, 64'd1);
    check("w8_operation", {60'd0, Operation_8}, 64'd2);
    $display("[TB] w8 add: result 0x%0h zero %b", Result_8, Zero_8);
    @(negedge CLOCK);
    OutReady_8 = 1'b1;
    @(posedge CLOCK);
    #1;
    OutReady_8 = 1'b0;
    check("w8_outvalid_low", {63'd0, OutValid_8}, 64'd0);
    check("w8_inready_high", {63'd0, InReady_8}, 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
